// File: rtl/alu_operand_loader.sv
// alu_operand_loader: gathers one (NOT) or two (AND/OR/ADD) operand words into a registered ALU operation
// clk/rst: single clock, synchronous active-high reset
// data_in/op_in/in_valid/in_ready: upstream word handshake; op_in taken with the first word only
// a_out/b_out/op_out/out_valid/out_ready: registered operation handed downstream
// op_count: operations consumed downstream, modulo 256
module alu_operand_loader #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic [1:0]       op_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic [1:0]       op_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       op_count
);
  typedef enum logic [1:0] {IDLE, WAIT_B, PRESENT} state_t;
  state_t state, next;
  logic acc;
  assign in_ready  = state != PRESENT;
  assign out_valid = state == PRESENT;
  assign acc       = in_valid && in_ready;
  always_comb
    next = state == IDLE   ? (acc ? (op_in == 2'b00 ? PRESENT : WAIT_B) : IDLE) :
           state == WAIT_B ? (acc ? PRESENT : WAIT_B) :
           (out_ready ? IDLE : PRESENT);
  always_ff @(posedge clk)
    state <= rst ? IDLE : next;
  always_ff @(posedge clk) begin
    if (rst) begin
      a_out    <= '0;
      b_out    <= '0;
      op_out   <= 2'b00;
      op_count <= 8'd0;
    end else begin
      if (state == IDLE && acc) begin
        a_out  <= data_in;
        op_out <= op_in;
        if (op_in == 2'b00) b_out <= '0;
      end
      if (state == WAIT_B && acc) b_out <= data_in;
      if (out_valid && out_ready) op_count <= op_count + 8'd1;
    end
  end
endmodule
